ahfp_sub_ci: RTL and testbench
==============================

# ahfp_sub_ci

Nios II multi-cycle custom-instruction front end for the pipelined floating-point subtractor core `ahfp_sub_multi`.
- Captures operands on `start` and resolves IEEE-754 special operands (zero, Inf, NaN) itself in one cycle.
- Otherwise holds the operands stable at the core's inputs, counts the core's fixed latency and pulses `done` with the core's result.
- Sits between the Nios II custom-instruction port and the subtractor core; it is the block that feeds the core and consumes its output.

## Interface
- `LATENCY`, 7: pipeline depth of the subtractor core, in clocks from stable inputs to valid output.
- `QNAN`, 32'h7FC00000: canonical quiet-NaN result.
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `clk_en` in 1: Nios clock enable; when low, every register in this block holds its value.
- `start` in 1: one-cycle request; qualified by `clk_en`.
- `dataa` in 32: minuend, IEEE-754 single precision.
- `datab` in 32: subtrahend, IEEE-754 single precision.
- `done` out 1: one-cycle pulse; `result` is valid in the same cycle.
- `result` out 32: registered difference; holds its value until the next `done`.

## Operation
- Registers: `op_a`, `op_b` (operand capture), `state`, `cnt` (4-bit), `result`, `done`.
- The core instance is fed from `op_a` and `op_b` only. The core is free-running.
- Operand classes, evaluated on `dataa` and `datab` in the cycle `start` is accepted:
  - zero: exponent 0. Denormals are flushed to zero.
  - inf: exponent FF, mantissa 0.
  - nan: exponent FF, mantissa nonzero.
- Special-case priority:
  1. Either operand nan -> `QNAN`.
  2. Both inf with equal signs -> `QNAN`.
  3. a inf -> a.
  4. b inf -> b with sign inverted.
  5. Both zero -> 32'h00000000.
  6. b zero -> a.
  7. a zero -> b with sign inverted.
- State machine: IDLE, RUN, FIN.
  - IDLE, `start` & special -> `result` <= special value, `done` <= 1, stay IDLE.
  - IDLE, `start` & normal -> latch `op_a`/`op_b`, `cnt` <= 0, go to RUN.
  - RUN -> `cnt` increments each enabled cycle. When `cnt` == `LATENCY`-1, go to FIN.
  - FIN -> `result` <= core output, `done` <= 1, go to IDLE.
- `start` while in RUN or FIN is ignored. Nios never issues it; it must not corrupt the operation in flight.
- `done` is cleared on every enabled cycle in which it is not being set.
- With `clk_en` low, state, `cnt` and `op_*` freeze. The core keeps clocking on constant inputs, so its output is stable when the count resumes.

## Timing
- Reset values: `done` 0, `result` 32'h0, `state` IDLE, `cnt` 0, `op_a` 0, `op_b` 0.
- Special path: `start` accepted at edge N -> `done`=1 with `result` after edge N, visible in cycle N+1.
- Normal path: `start` at edge N -> `op_*` stable from N+1 -> `done` visible in cycle N+`LATENCY`+2. With `LATENCY` 7 this is 9 cycles after the `start` cycle.
- Each cycle with `clk_en` low adds one cycle of latency.
- If `start` and `clk_en` are both high in the cycle `done` is visible (IDLE, back-to-back), the new operation is accepted.
- `reset` mid-RUN:
  - Returns to IDLE with no `done` pulse.
  - The core's stale pipeline contents are never sampled, because sampling happens only in FIN.
- `reset` overrides `start` and `clk_en` in the same cycle.

## Structure
- Shared package `ahfp_pkg` holds:
  - `FP_EXP_MAX` = 8'hFF.
  - `QNAN` value.
  - Field-slice constants for sign, exponent and mantissa.
  - State encoding: IDLE=2'd0, RUN=2'd1, FIN=2'd2.
- One sub-module: the existing `ahfp_sub_multi` core, instantiated once.
- Special-case classification is a function in `ahfp_pkg`, so other `ahfp_*_ci` blocks can reuse it.

## Test plan
- Normal subtraction: `dataa`=40400000 (3.0), `datab`=3F800000 (1.0), `start` at cycle 0 -> single `done` pulse at cycle 9, `result`=40000000.
- Bypass: `dataa`=40400000, `datab`=00000000 -> `done` at cycle 1, `result`=40400000. Then `dataa`=0, `datab`=3F800000 -> `result`=BF800000.
- NaN and Inf:
  - `dataa`=7F800001 -> `result` 7FC00000.
  - `dataa`=`datab`=7F800000 -> 7FC00000.
  - `dataa`=3F800000, `datab`=FF800000 -> 7F800000.
- Stall: 3.0-1.0 with `clk_en` low at cycles 3-5 -> `done` at cycle 12, `result`=40000000, `done` width exactly one cycle.
- Protocol:
  - `start` with 41200000/3F800000 at cycle 4 of a run -> ignored; the first operation's result 40000000 is delivered at cycle 9.
  - `reset` at cycle 5 -> no `done` pulse, `result`=0.
  - Next `start` after reset completes normally.

Source files
------------

// File: rtl/ahfp_pkg.sv
// ahfp_pkg: constants, state encoding and the special-operand classifier
// shared by the ahfp_*_ci custom-instruction front ends.
package ahfp_pkg;

  localparam logic [7:0]  FP_EXP_MAX = 8'hFF;
  localparam logic [31:0] FP_QNAN    = 32'h7FC00000;

  // IEEE-754 single-precision field positions
  localparam int FP_SIGN_BIT = 31;
  localparam int FP_EXP_MSB  = 30;
  localparam int FP_EXP_LSB  = 23;
  localparam int FP_MAN_MSB  = 22;
  localparam int FP_MAN_LSB  = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } ci_state_t;

  // special: the operation is fully resolved without the core.
  // qnan:    the answer is the canonical quiet NaN (value is then don't-care).
  typedef struct packed {
    logic        special;
    logic        qnan;
    logic [31:0] value;
  } fp_spec_t;

  // Classifies a - b. Denormals count as zero (flush-to-zero).
  function automatic fp_spec_t fp_sub_special(input logic [31:0] a,
                                              input logic [31:0] b);
    fp_spec_t   r;
    logic       sa, sb;
    logic [7:0] ea, eb;
    logic       ma_nz, mb_nz;
    logic       a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    sa     = a[FP_SIGN_BIT];
    sb     = b[FP_SIGN_BIT];
    ea     = a[FP_EXP_MSB:FP_EXP_LSB];
    eb     = b[FP_EXP_MSB:FP_EXP_LSB];
    ma_nz  = |a[FP_MAN_MSB:FP_MAN_LSB];
    mb_nz  = |b[FP_MAN_MSB:FP_MAN_LSB];
    a_zero = (ea == 8'd0);
    b_zero = (eb == 8'd0);
    a_inf  = (ea == FP_EXP_MAX) && !ma_nz;
    b_inf  = (eb == FP_EXP_MAX) && !mb_nz;
    a_nan  = (ea == FP_EXP_MAX) && ma_nz;
    b_nan  = (eb == FP_EXP_MAX) && mb_nz;

    r.special = 1'b1;
    r.qnan    = 1'b0;
    r.value   = 32'h0;
    if (a_nan || b_nan) begin
      r.qnan  = 1'b1;
      r.value = FP_QNAN;
    end else if (a_inf && b_inf && (sa == sb)) begin
      // inf - inf of the same sign is undefined
      r.qnan  = 1'b1;
      r.value = FP_QNAN;
    end else if (a_inf) begin
      r.value = a;
    end else if (b_inf) begin
      r.value = {~sb, b[FP_EXP_MSB:FP_MAN_LSB]};
    end else if (a_zero && b_zero) begin
      r.value = 32'h0;
    end else if (b_zero) begin
      r.value = a;
    end else if (a_zero) begin
      r.value = {~sb, b[FP_EXP_MSB:FP_MAN_LSB]};
    end else begin
      r.special = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/ahfp_sub_multi.sv
// ahfp_sub_multi: free-running pipelined single-precision subtractor.
// Operands are assumed normal and finite (the front end resolves zero,
// denormal, Inf and NaN). Round-to-nearest-even; overflow gives Inf,
// underflow flushes to signed zero.
// Ports:
//   i_clk  - clock
//   i_a    - minuend
//   i_b    - subtrahend
//   o_res  - i_a - i_b, STAGES clocks after the operands are applied
module ahfp_sub_multi #(
  parameter int STAGES = 7
) (
  input  logic        i_clk,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_res
);

  // Index of the most significant set bit, expressed as a left-shift count.
  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] c;
    c = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (v[i]) c = 5'(26 - i);
    end
    return c;
  endfunction

  // Round-to-nearest-even on {mant[23:0], G, R, S}, then pack with
  // overflow to Inf and underflow to zero.
  function automatic logic [31:0] rne_pack(input logic              s,
                                           input logic signed [9:0] e,
                                           input logic [26:0]       n,
                                           input logic              z);
    logic              inc;
    logic [24:0]       m;
    logic signed [9:0] ee;
    inc = n[2] & (n[1] | n[0] | n[3]);
    m   = {1'b0, n[26:3]} + {24'd0, inc};
    ee  = e;
    if (m[24]) begin
      m  = m >> 1;
      ee = ee + 10'sd1;
    end
    if (z)                  return 32'h0;
    else if (ee >= 10'sd255) return {s, 8'hFF, 23'd0};
    else if (ee <= 10'sd0)   return {s, 31'd0};
    else                     return {s, ee[7:0], m[22:0]};
  endfunction

  // ---- stage p1: negate b, order by magnitude, exponent difference
  logic [31:0] w_b_neg, w_x, w_y;
  logic        w_swap;
  assign w_b_neg = {~i_b[31], i_b[30:0]};
  assign w_swap  = (i_b[30:0] > i_a[30:0]);
  assign w_x     = w_swap ? w_b_neg : i_a;
  assign w_y     = w_swap ? i_a : w_b_neg;

  logic        r_sx_p1, r_sub_p1;
  logic [7:0]  r_ex_p1, r_d_p1;
  logic [23:0] r_mx_p1, r_my_p1;
  always_ff @(posedge i_clk) begin
    r_sx_p1  <= w_x[31];
    r_sub_p1 <= w_x[31] ^ w_y[31];
    r_ex_p1  <= w_x[30:23];
    r_d_p1   <= w_x[30:23] - w_y[30:23];
    r_mx_p1  <= {1'b1, w_x[22:0]};
    r_my_p1  <= {1'b1, w_y[22:0]};
  end

  // ---- stage p2: align the smaller operand, keeping guard/round/sticky
  logic [49:0] w_wide;
  logic [26:0] w_my_al;
  assign w_wide  = {r_my_p1, 26'd0} >> r_d_p1;
  // beyond 49 places every bit is gone, but the operand was nonzero
  assign w_my_al = (r_d_p1 >= 8'd50) ? 27'd1
                                     : {w_wide[49:24], w_wide[23] | (|w_wide[22:0])};

  logic        r_sx_p2, r_sub_p2;
  logic [7:0]  r_ex_p2;
  logic [26:0] r_mx_p2, r_my_p2;
  always_ff @(posedge i_clk) begin
    r_sx_p2  <= r_sx_p1;
    r_sub_p2 <= r_sub_p1;
    r_ex_p2  <= r_ex_p1;
    r_mx_p2  <= {r_mx_p1, 3'b000};
    r_my_p2  <= w_my_al;
  end

  // ---- stage p3: magnitude add/subtract (x >= y, so never negative)
  logic [27:0] w_sum;
  assign w_sum = r_sub_p2 ? ({1'b0, r_mx_p2} - {1'b0, r_my_p2})
                          : ({1'b0, r_mx_p2} + {1'b0, r_my_p2});

  logic        r_sx_p3;
  logic [7:0]  r_ex_p3;
  logic [27:0] r_sum_p3;
  always_ff @(posedge i_clk) begin
    r_sx_p3  <= r_sx_p2;
    r_ex_p3  <= r_ex_p2;
    r_sum_p3 <= w_sum;
  end

  // ---- stage p4: normalize so the hidden bit sits at n[26]
  logic [4:0]        w_lz;
  logic [26:0]       w_n;
  logic signed [9:0] w_e;
  assign w_lz = lzc27(r_sum_p3[26:0]);
  always_comb begin
    w_n = r_sum_p3[26:0] << w_lz;
    w_e = $signed({2'b00, r_ex_p3}) - $signed({5'd0, w_lz});
    if (r_sum_p3[27]) begin
      w_n = {r_sum_p3[27:2], r_sum_p3[1] | r_sum_p3[0]};
      w_e = $signed({2'b00, r_ex_p3}) + 10'sd1;
    end
  end

  logic              r_s_p4, r_z_p4;
  logic signed [9:0] r_e_p4;
  logic [26:0]       r_n_p4;
  always_ff @(posedge i_clk) begin
    r_s_p4 <= r_sx_p3;
    r_z_p4 <= (r_sum_p3 == 28'd0);
    r_e_p4 <= w_e;
    r_n_p4 <= w_n;
  end

  // ---- stage p5: round and pack
  logic [31:0] r_res_p5;
  always_ff @(posedge i_clk) begin
    r_res_p5 <= rne_pack(r_s_p4, r_e_p4, r_n_p4, r_z_p4);
  end

  // ---- stages p6..: delay to the advertised latency
  generate
    if (STAGES > 5) begin : g_dly
      logic [31:0] r_dly [STAGES-5];
      always_ff @(posedge i_clk) begin
        r_dly[0] <= r_res_p5;
        for (int i = 1; i < STAGES - 5; i++) r_dly[i] <= r_dly[i-1];
      end
      assign o_res = r_dly[STAGES-6];
    end else begin : g_nodly
      assign o_res = r_res_p5;
    end
  endgenerate

endmodule

// File: rtl/ahfp_sub_ci.sv
// ahfp_sub_ci: Nios II multi-cycle custom instruction computing
// dataa - datab in single precision. Zero/denormal/Inf/NaN cases are
// answered in one cycle; otherwise the operands are held at the inputs of
// ahfp_sub_multi for LATENCY clocks and its output is returned.
// Ports:
//   clk, reset     - clock, synchronous active-high reset
//   clk_en         - Nios clock enable; low freezes every register here
//   start          - one-cycle request (qualified by clk_en)
//   dataa, datab   - minuend, subtrahend
//   done           - one-cycle completion pulse
//   result         - difference, held until the next done
module ahfp_sub_ci #(
  parameter int          LATENCY = 7,
  parameter logic [31:0] QNAN    = 32'h7FC00000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        start,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  output logic        done,
  output logic [31:0] result
);
  import ahfp_pkg::*;

  ci_state_t   r_state;
  logic [3:0]  r_cnt;
  logic [31:0] r_op_a, r_op_b;
  logic [31:0] r_result;
  logic        r_done;
  fp_spec_t    w_spec;
  logic [31:0] w_core_res;

  assign w_spec = fp_sub_special(dataa, datab);

  // The core only ever sees the captured operands, so with clk_en low it
  // keeps computing on constant inputs and its output stays valid.
  ahfp_sub_multi #(
    .STAGES (LATENCY)
  ) u_core (
    .i_clk (clk),
    .i_a   (r_op_a),
    .i_b   (r_op_b),
    .o_res (w_core_res)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= 4'd0;
      r_op_a   <= 32'h0;
      r_op_b   <= 32'h0;
      r_result <= 32'h0;
      r_done   <= 1'b0;
    end else if (clk_en) begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (w_spec.special) begin
              r_result <= w_spec.qnan ? QNAN : w_spec.value;
              r_done   <= 1'b1;
            end else begin
              r_op_a  <= dataa;
              r_op_b  <= datab;
              r_cnt   <= 4'd0;
              r_state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          // start is not looked at here, so a stray request cannot disturb
          // the operands in flight
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == 4'(LATENCY - 1)) r_state <= ST_FIN;
        end
        ST_FIN: begin
          r_result <= w_core_res;
          r_done   <= 1'b1;
          r_state  <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign done   = r_done;
  assign result = r_result;

endmodule

// File: tb/tb_ahfp_sub_ci.sv
module tb_ahfp_sub_ci;

  logic        clk = 1'b0;
  logic        reset, clk_en, start;
  logic [31:0] dataa, datab;
  logic        done;
  logic [31:0] result;

  int n_vec = 0;
  int n_err = 0;

  ahfp_sub_ci #(.LATENCY(7), .QNAN(32'h7FC00000)) dut (
    .clk    (clk),
    .reset  (reset),
    .clk_en (clk_en),
    .start  (start),
    .dataa  (dataa),
    .datab  (datab),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
  } vec_t;

  vec_t vecs[17];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Issues one request in the current cycle; returns the cycle count until
  // done is seen (30 means it never came) and the result in that cycle.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] res);
    dataa = a;
    datab = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 30) begin
      tick();
      lat++;
    end
    res = result;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          lat, first_done, n_done;
    logic [31:0] res, res_at_done;

    vecs[0]  = '{32'h40400000, 32'h3F800000, 32'h40000000, 9}; // 3 - 1
    vecs[1]  = '{32'h40400000, 32'h00000000, 32'h40400000, 1}; // b zero
    vecs[2]  = '{32'h00000000, 32'h3F800000, 32'hBF800000, 1}; // a zero
    vecs[3]  = '{32'h7F800001, 32'h3F800000, 32'h7FC00000, 1}; // a nan
    vecs[4]  = '{32'h7F800000, 32'h7F800000, 32'h7FC00000, 1}; // inf - inf
    vecs[5]  = '{32'h3F800000, 32'hFF800000, 32'h7F800000, 1}; // 1 - (-inf)
    vecs[6]  = '{32'h3F800000, 32'h7F800000, 32'hFF800000, 1}; // 1 - inf
    vecs[7]  = '{32'hFF800000, 32'h7F800000, 32'hFF800000, 1}; // -inf - inf
    vecs[8]  = '{32'h3F800000, 32'h3F800000, 32'h00000000, 9}; // exact cancel
    vecs[9]  = '{32'h3F800000, 32'h40000000, 32'hBF800000, 9}; // 1 - 2
    vecs[10] = '{32'h3FC00000, 32'hBF000000, 32'h40000000, 9}; // 1.5 + 0.5 carry
    vecs[11] = '{32'h00400000, 32'h3F800000, 32'hBF800000, 1}; // denormal a
    vecs[12] = '{32'h3F800001, 32'h3F800000, 32'h34000000, 9}; // deep normalize
    vecs[13] = '{32'h3F800000, 32'hB3800000, 32'h3F800000, 9}; // tie, even
    vecs[14] = '{32'h3F800001, 32'hB3800000, 32'h3F800002, 9}; // tie, round up
    vecs[15] = '{32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, 9}; // overflow
    vecs[16] = '{32'h3F800000, 32'hFFC00000, 32'h7FC00000, 1}; // b nan

    reset  = 1'b1;
    clk_en = 1'b1;
    start  = 1'b0;
    dataa  = 32'h0;
    datab  = 32'h0;
    tick();
    tick();
    check32("reset_done", {31'd0, done}, 32'h0);
    check32("reset_result", result, 32'h0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 17; i++) begin
      run_op(vecs[i].a, vecs[i].b, lat, res);
      check_int($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      check32($sformatf("vec%0d_result", i), res, vecs[i].res);
      tick();
      check32($sformatf("vec%0d_done_width", i), {31'd0, done}, 32'h0);
    end

    // Stall: clk_en low during cycles 3..5 pushes done from 9 to 12.
    dataa = 32'h40400000;
    datab = 32'h3F800000;
    start = 1'b1;
    tick();
    start = 1'b0;
    first_done = 0;
    n_done = 0;
    res_at_done = 32'h0;
    for (int c = 1; c <= 16; c++) begin
      if (done === 1'b1) begin
        n_done++;
        if (first_done == 0) begin
          first_done = c;
          res_at_done = result;
        end
      end
      clk_en = (c >= 3 && c <= 5) ? 1'b0 : 1'b1;
      tick();
    end
    clk_en = 1'b1;
    check_int("stall_done_cycle", first_done, 12);
    check_int("stall_done_count", n_done, 1);
    check32("stall_result", res_at_done, 32'h40000000);

    // A start in the middle of a run is ignored.
    dataa = 32'h40400000;
    datab = 32'h3F800000;
    start = 1'b1;
    tick();
    start = 1'b0;
    first_done = 0;
    n_done = 0;
    res_at_done = 32'h0;
    for (int c = 1; c <= 14; c++) begin
      if (done === 1'b1) begin
        n_done++;
        if (first_done == 0) begin
          first_done = c;
          res_at_done = result;
        end
      end
      if (c == 4) begin
        dataa = 32'h41200000;
        datab = 32'h3F800000;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    check_int("ignore_done_cycle", first_done, 9);
    check_int("ignore_done_count", n_done, 1);
    check32("ignore_result", res_at_done, 32'h40000000);

    // Reset in cycle 5 of a run: no done, result cleared.
    dataa = 32'h40400000;
    datab = 32'h3F800000;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_done = 0;
    for (int c = 1; c <= 14; c++) begin
      if (done === 1'b1) n_done++;
      reset = (c == 5) ? 1'b1 : 1'b0;
      tick();
    end
    reset = 1'b0;
    check_int("midrun_reset_done_count", n_done, 0);
    check32("midrun_reset_result", result, 32'h0);

    run_op(32'h40400000, 32'h3F800000, lat, res);
    check_int("after_reset_latency", lat, 9);
    check32("after_reset_result", res, 32'h40000000);

    // Back-to-back: a new start in the done cycle is accepted.
    run_op(32'h40400000, 32'h00000000, lat, res);
    check_int("b2b_latency", lat, 1);
    check32("b2b_result", res, 32'h40400000);
    tick();

    // Reset wins over a simultaneous start.
    dataa = 32'h40400000;
    datab = 32'h00000000;
    start = 1'b1;
    reset = 1'b1;
    tick();
    start = 1'b0;
    reset = 1'b0;
    check32("reset_over_start_done", {31'd0, done}, 32'h0);
    check32("reset_over_start_result", result, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
